// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul result path: result-BRAM geometry helpers
// and the drain FSM state encoding.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } stream_state_t;

    function automatic int calc_num_words(input int w_outer, input int chunk, input int i_outer);
        return (w_outer / chunk) * i_outer;
    endfunction

    // A single-word BRAM still needs a one-bit address port.
    function automatic int calc_addr_width(input int num_words);
        return ($clog2(num_words) < 1) ? 1 : $clog2(num_words);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO feeding the result stream; the caller guarantees it
// never pushes into a full FIFO nor pops an empty one.
module stream_fifo2 #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/result_streamer.sv
// Drains the matmul result BRAM in address order onto an AXI-Stream style
// output, throttling reads so the 2-entry output FIFO can absorb any stall.
module result_streamer
    import matmul_pkg::*;
#(
    parameter int WIDTH              = 16,
    parameter int FRAC_WIDTH         = 8,
    parameter int CHUNK_SIZE         = 4,
    parameter int W_OUTER_DIMENSION  = 64,
    parameter int I_OUTER_DIMENSION  = 2754,
    localparam int NUM_WORDS  = calc_num_words(W_OUTER_DIMENSION, CHUNK_SIZE, I_OUTER_DIMENSION),
    localparam int ADDR_WIDTH = calc_addr_width(NUM_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        out_en,
    output logic [ADDR_WIDTH-1:0]       out_addr,
    input  logic [WIDTH*CHUNK_SIZE-1:0] out_dout,
    output logic [WIDTH*CHUNK_SIZE-1:0] m_tdata,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    output logic                        m_tlast
);

    localparam int DW = WIDTH * CHUNK_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    if (FRAC_WIDTH >= WIDTH) begin : g_frac_check
        $error("result_streamer: FRAC_WIDTH must be smaller than WIDTH");
    end

    stream_state_t         r_state;
    stream_state_t         w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_out_cnt;
    logic                  r_rd_pend;
    logic [1:0]            w_occ;
    logic [2:0]            w_commit;
    logic                  w_pop;
    logic                  w_start_ok;

    assign w_pop      = m_tvalid & m_tready;
    assign w_start_ok = (r_state == IDLE) & start;
    // Words that will still be held after this edge; a read issued now lands
    // two edges later, so counting the concurrent pop keeps 1 word/cycle.
    assign w_commit   = {1'b0, w_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        out_en = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = READ;
            end
            READ: begin
                out_en = (w_commit < 3'd2);
                if (out_en && (r_addr == LAST_ADDR)) w_next = DRAIN;
            end
            DRAIN: begin
                if (w_pop && (r_out_cnt == LAST_ADDR)) w_next = FINISH;
            end
            FINISH: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_out_cnt <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_pend <= out_en;
            if (w_start_ok) begin
                r_addr <= '0;
            end else if (out_en && (r_addr != LAST_ADDR)) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_start_ok) begin
                r_out_cnt <= '0;
            end else if (w_pop && (r_out_cnt != LAST_ADDR)) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
        end
    end

    // BRAM data is valid the cycle after out_en, so the registered read flag is the push.
    stream_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_rd_pend),
        .i_data (out_dout),
        .i_pop  (w_pop),
        .o_data (m_tdata),
        .o_count(w_occ)
    );

    assign out_addr = r_addr;
    assign m_tvalid = (w_occ != 2'd0);
    assign m_tlast  = m_tvalid & (r_out_cnt == LAST_ADDR);

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer with a 6-word result BRAM (word[a] = a + 0x100).
module tb_result_streamer;

    localparam int AW = 3;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          out_en;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_dout = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;

    int total = 0;
    int bad   = 0;

    result_streamer #(
        .WIDTH            (16),
        .FRAC_WIDTH       (8),
        .CHUNK_SIZE       (4),
        .W_OUTER_DIMENSION(8),
        .I_OUTER_DIMENSION(3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .out_en  (out_en),
        .out_addr(out_addr),
        .out_dout(out_dout),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast (m_tlast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_en) out_dout <= 64'h100 + 64'(out_addr);
    end

    // Observation log, written only here and read by the tests.
    logic [DW-1:0] wq[$];
    logic          lq[$];
    int            acq[$];
    int            aq[$];
    int            dq[$];
    int            cyc = 0;
    int            outst = 0;
    int            stall_err = 0;
    int            commit_err = 0;
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic          prev_l = 1'b0;
    logic [DW-1:0] prev_d = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            outst  = 0;
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r && !(m_tvalid === 1'b1 && m_tdata === prev_d && m_tlast === prev_l))
                stall_err++;
            if (out_en) begin
                aq.push_back(int'(out_addr));
                outst++;
            end
            if (m_tvalid && m_tready) begin
                wq.push_back(m_tdata);
                lq.push_back(m_tlast);
                acq.push_back(cyc);
                outst--;
            end
            if (outst > 2) commit_err++;
            if (done) dq.push_back(cyc);
            prev_v = m_tvalid;
            prev_r = m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        m_tready = 1'b0;
        repeat (3) tick();
        total++;
        if ({busy, done, out_en, m_tvalid, m_tlast} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy/done/out_en/tvalid/tlast=%b want 00000",
                     {busy, done, out_en, m_tvalid, m_tlast});
        end
        total++;
        if (out_addr !== '0) begin
            bad++;
            $display("FAIL reset_addr: got %0d want 0", out_addr);
        end
        total++;
        if (m_tdata !== '0) begin
            bad++;
            $display("FAIL reset_tdata: got %h want 0", m_tdata);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        total++;
        if (busy !== 1'b0 || out_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b out_en=%b want 0 0", busy, out_en);
        end
    endtask

    task automatic test_basic();
        int w0, a0, d0, lat, n;
        w0 = wq.size();
        a0 = aq.size();
        d0 = dq.size();
        m_tready = 1'b1;
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        lat = 0;
        while (m_tvalid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (lat != 2) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 2", lat);
        end
        wait_done(100, n);
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL basic_done_timeout: waited %0d cycles", n);
        end
        total++;
        if (wq.size() - w0 != 6) begin
            bad++;
            $display("FAIL basic_count: got %0d words want 6", wq.size() - w0);
        end
        for (int i = 0; i < 6 && w0 + i < wq.size(); i++) begin
            total++;
            if (wq[w0+i] !== 64'h100 + 64'(i) || lq[w0+i] !== (i == 5)) begin
                bad++;
                $display("FAIL basic_word[%0d]: got %h last=%b want %h last=%b",
                         i, wq[w0+i], lq[w0+i], 64'h100 + 64'(i), (i == 5));
            end
        end
        for (int i = 0; i < 6 && a0 + i < aq.size(); i++) begin
            total++;
            if (aq[a0+i] != i) begin
                bad++;
                $display("FAIL basic_addr[%0d]: got %0d want %0d", i, aq[a0+i], i);
            end
        end
        total++;
        if (acq.size() < w0 + 6 || acq[w0+5] - acq[w0] != 5) begin
            bad++;
            $display("FAIL basic_rate: words not on consecutive cycles");
        end
        total++;
        if (dq.size() - d0 != 1 || acq.size() < w0 + 6 || dq[d0] != acq[w0+5] + 1) begin
            bad++;
            $display("FAIL basic_done: got %0d done pulses want 1, one cycle after last word",
                     dq.size() - d0);
        end
    endtask

    task automatic test_toggle();
        bit pat[4];
        int w0, a0, s0, c0, c;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        w0 = wq.size();
        a0 = aq.size();
        s0 = stall_err;
        c0 = commit_err;
        m_tready = pat[0];
        pulse_start();
        c = 1;
        while (done !== 1'b1 && c < 300) begin
            m_tready = pat[c % 4];
            tick();
            c++;
        end
        tick();
        m_tready = 1'b1;
        total++;
        if (c >= 300) begin
            bad++;
            $display("FAIL toggle_timeout: no done after %0d cycles", c);
        end
        total++;
        if (wq.size() - w0 != 6 || aq.size() - a0 != 6) begin
            bad++;
            $display("FAIL toggle_count: got %0d words %0d reads want 6 6",
                     wq.size() - w0, aq.size() - a0);
        end
        for (int i = 0; i < 6 && w0 + i < wq.size(); i++) begin
            total++;
            if (wq[w0+i] !== 64'h100 + 64'(i) || lq[w0+i] !== (i == 5)) begin
                bad++;
                $display("FAIL toggle_word[%0d]: got %h last=%b want %h last=%b",
                         i, wq[w0+i], lq[w0+i], 64'h100 + 64'(i), (i == 5));
            end
        end
        total++;
        if (stall_err != s0) begin
            bad++;
            $display("FAIL toggle_stable: got %0d unstable stall cycles want 0", stall_err - s0);
        end
        total++;
        if (commit_err != c0) begin
            bad++;
            $display("FAIL toggle_overcommit: got %0d cycles above 2 committed want 0",
                     commit_err - c0);
        end
    endtask

    task automatic test_stall();
        int w0, a0, n;
        w0 = wq.size();
        a0 = aq.size();
        m_tready = 1'b0;
        pulse_start();
        repeat (20) tick();
        total++;
        if (aq.size() - a0 != 2 || aq.size() < a0 + 2 || aq[a0] != 0 || aq[a0+1] != 1) begin
            bad++;
            $display("FAIL stall_reads: got %0d reads want 2 (addr 0,1)", aq.size() - a0);
        end
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== 64'h100 || m_tlast !== 1'b0) begin
            bad++;
            $display("FAIL stall_head: got valid=%b data=%h last=%b want 1 100 0",
                     m_tvalid, m_tdata, m_tlast);
        end
        total++;
        if (out_en !== 1'b0) begin
            bad++;
            $display("FAIL stall_out_en: got %b want 0", out_en);
        end
        m_tready = 1'b1;
        wait_done(100, n);
        total++;
        if (wq.size() - w0 != 6) begin
            bad++;
            $display("FAIL stall_count: got %0d words want 6", wq.size() - w0);
        end
        for (int i = 0; i < 6 && w0 + i < wq.size(); i++) begin
            total++;
            if (wq[w0+i] !== 64'h100 + 64'(i) || lq[w0+i] !== (i == 5)) begin
                bad++;
                $display("FAIL stall_word[%0d]: got %h last=%b want %h last=%b",
                         i, wq[w0+i], lq[w0+i], 64'h100 + 64'(i), (i == 5));
            end
        end
    endtask

    task automatic test_double_start();
        int w0, d0, n;
        w0 = wq.size();
        d0 = dq.size();
        m_tready = 1'b1;
        pulse_start();
        tick();
        pulse_start();
        wait_done(100, n);
        repeat (10) tick();
        total++;
        if (wq.size() - w0 != 6 || dq.size() - d0 != 1) begin
            bad++;
            $display("FAIL double_start: got %0d words %0d dones want 6 1",
                     wq.size() - w0, dq.size() - d0);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL double_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int w0, w1, a1, n;
        w0 = wq.size();
        m_tready = 1'b1;
        pulse_start();
        n = 0;
        while (wq.size() - w0 < 4 && n < 50) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, out_en, m_tvalid, m_tlast} !== 5'b0 || out_addr !== '0 || m_tdata !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: ctrl=%b addr=%0d data=%h want all 0",
                     {busy, done, out_en, m_tvalid, m_tlast}, out_addr, m_tdata);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        w1 = wq.size();
        repeat (5) tick();
        total++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || wq.size() != w1) begin
            bad++;
            $display("FAIL midreset_idle: busy=%b tvalid=%b new words=%0d want 0 0 0",
                     busy, m_tvalid, wq.size() - w1);
        end
        w1 = wq.size();
        a1 = aq.size();
        pulse_start();
        wait_done(100, n);
        total++;
        if (wq.size() - w1 != 6 || aq.size() - a1 != 6) begin
            bad++;
            $display("FAIL midreset_count: got %0d words %0d reads want 6 6",
                     wq.size() - w1, aq.size() - a1);
        end
        for (int i = 0; i < 6 && w1 + i < wq.size() && a1 + i < aq.size(); i++) begin
            total++;
            if (wq[w1+i] !== 64'h100 + 64'(i) || aq[a1+i] != i || lq[w1+i] !== (i == 5)) begin
                bad++;
                $display("FAIL midreset_word[%0d]: got %h addr %0d want %h addr %0d",
                         i, wq[w1+i], aq[a1+i], 64'h100 + 64'(i), i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w0, d0, n;
        w0 = wq.size();
        d0 = dq.size();
        m_tready = 1'b1;
        pulse_start();
        wait_done(100, n);
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart: busy=%b want 1", busy);
        end
        wait_done(100, n);
        total++;
        if (wq.size() - w0 != 12 || dq.size() - d0 != 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d words %0d dones want 12 2",
                     wq.size() - w0, dq.size() - d0);
        end
        for (int i = 0; i < 12 && w0 + i < wq.size(); i++) begin
            total++;
            if (wq[w0+i] !== 64'h100 + 64'(i % 6) || lq[w0+i] !== (i % 6 == 5)) begin
                bad++;
                $display("FAIL b2b_word[%0d]: got %h last=%b want %h last=%b",
                         i, wq[w0+i], lq[w0+i], 64'h100 + 64'(i % 6), (i % 6 == 5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_double_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
